// File: rtl/fifo_drain_router_pkg.sv
// rtl/fifo_drain_router_pkg.sv - shared encodings for the FIFO drain router
package fifo_drain_router_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_RUN   = 2'd1,
        STATE_DRAIN = 2'd2
    } state_t;

    localparam int DEST_W  = 2;
    localparam int NUM_DST = 4;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - 2-entry in-order buffer; head is the oldest word
module skid_buf2 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] tail;
    logic         do_pop;

    assign do_pop = pop && (count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count stays put; the new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_drain_router.sv
// rtl/fifo_drain_router.sv - drains one upstream FIFO and routes words to four egress FIFOs by dest field
module fifo_drain_router
    import fifo_drain_router_pkg::*;
#(
    parameter int WORD_SIZE = 10,
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 enable,
    input  logic                 src_empty,
    input  logic [WORD_SIZE-1:0] src_data,
    output logic                 src_rd,
    input  logic [NUM_DST-1:0]   dst_almost_full,
    output logic [NUM_DST-1:0]   dst_push,
    output logic [WORD_SIZE-1:0] dst_data,
    output logic                 idle,
    output logic                 stall_err,
    output logic [CNT_W-1:0]     fwd_count
);

    localparam int STALL_W = $clog2(STALL_MAX + 1);

    state_t               state, state_nxt;
    logic                 rd_pending;
    logic [1:0]           hold_cnt;
    logic [WORD_SIZE-1:0] head;
    logic [DEST_W-1:0]    head_dest;
    logic                 pop_now;
    logic [STALL_W-1:0]   stall_cnt;

    skid_buf2 #(.W(WORD_SIZE)) u_buf (
        .clk   (clk),
        .rst_n (reset_L),
        .push  (rd_pending),
        .pop   (pop_now),
        .din   (src_data),
        .head  (head),
        .count (hold_cnt)
    );

    assign head_dest = head[WORD_SIZE-1 -: DEST_W];
    assign pop_now   = (hold_cnt != 2'd0) && !dst_almost_full[head_dest];

    // Occupancy after this cycle (buffer + returning word - departing word) must stay below 2.
    assign src_rd = (state == STATE_RUN) && !src_empty &&
                    (({1'b0, hold_cnt} + {2'b00, rd_pending}) < (3'd2 + {2'b00, pop_now}));

    assign idle = (state == STATE_IDLE) && !rd_pending && (hold_cnt == 2'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            STATE_IDLE:  if (enable) state_nxt = STATE_RUN;
            STATE_RUN:   if (!enable) state_nxt = STATE_DRAIN;
            STATE_DRAIN: begin
                if (enable)
                    state_nxt = STATE_RUN;
                else if (!rd_pending && (hold_cnt == 2'd0))
                    state_nxt = STATE_IDLE;
            end
            default:     state_nxt = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= STATE_IDLE;
            rd_pending <= 1'b0;
            dst_push   <= '0;
            dst_data   <= '0;
            fwd_count  <= '0;
            stall_cnt  <= '0;
            stall_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_pending <= src_rd;
            if (pop_now) begin
                dst_push  <= NUM_DST'(1) << head_dest;
                dst_data  <= head;
                fwd_count <= fwd_count + 1'b1;
                stall_cnt <= '0;
            end else begin
                dst_push <= '0;
                if (hold_cnt != 2'd0) begin
                    if (int'(stall_cnt) < STALL_MAX)
                        stall_cnt <= stall_cnt + 1'b1;
                    // Sets on the cycle the blocked count reaches STALL_MAX.
                    if (int'(stall_cnt) >= STALL_MAX - 1)
                        stall_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_router.sv
// tb/tb_fifo_drain_router.sv - directed and randomized checks of fifo_drain_router against a queue model
module tb_fifo_drain_router;

    localparam int WS   = 10;
    localparam int CW   = 4;
    localparam int SMAX = 15;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          enable;
    logic          src_empty;
    logic [WS-1:0] src_data;
    logic          src_rd;
    logic [3:0]    dst_almost_full;
    logic [3:0]    dst_push;
    logic [WS-1:0] dst_data;
    logic          idle;
    logic          stall_err;
    logic [CW-1:0] fwd_count;

    fifo_drain_router #(.WORD_SIZE(WS), .CNT_W(CW), .STALL_MAX(SMAX)) dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .enable          (enable),
        .src_empty       (src_empty),
        .src_data        (src_data),
        .src_rd          (src_rd),
        .dst_almost_full (dst_almost_full),
        .dst_push        (dst_push),
        .dst_data        (dst_data),
        .idle            (idle),
        .stall_err       (stall_err),
        .fwd_count       (fwd_count)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [WS-1:0] upq[$];
    logic [WS-1:0] exp_q[$];
    int            model_cnt = 0;
    logic [WS-1:0] prev_data = '0;
    logic          last_rd;
    logic [3:0]    last_push;
    int            n_push = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WS-1:0] mk(input int dest);
        logic [WS-1:0] w;
        w = WS'($urandom);
        w[WS-1:WS-2] = 2'(dest);
        return w;
    endfunction

    task automatic load(input logic [WS-1:0] w);
        upq.push_back(w);
        src_empty = 1'b0;
    endtask

    // One clock: upstream FIFO model answers reads one cycle later, scoreboard checks every push.
    task automatic tick();
        logic          rd;
        logic [3:0]    af;
        logic [WS-1:0] w;
        #1;
        rd = src_rd;
        af = dst_almost_full;
        if (src_empty) check("rd_while_empty", 32'(rd), 32'd0);
        @(posedge clk);
        #1;
        if (rd) begin
            src_data = upq.pop_front();
            exp_q.push_back(src_data);
        end else begin
            src_data = WS'($urandom);
        end
        src_empty = (upq.size() == 0);
        #1;
        last_rd   = rd;
        last_push = dst_push;
        if (dst_push != 4'd0) begin
            n_push++;
            if (exp_q.size() == 0) begin
                check("unexpected_push", 32'(dst_push), 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("push_data", 32'(dst_data), 32'(w));
                check("push_onehot", 32'(dst_push), 32'(4'd1 << w[WS-1:WS-2]));
                check("push_af_clear", 32'(af[w[WS-1:WS-2]]), 32'd0);
                model_cnt = (model_cnt + 1) % (1 << CW);
            end
        end else begin
            check("data_hold", 32'(dst_data), 32'(prev_data));
        end
        check("fwd_count", 32'(fwd_count), 32'(model_cnt));
        prev_data = dst_data;
    endtask

    initial begin
        logic       rd_log[0:15];
        logic [3:0] push_log[0:15];
        int         f;
        int         cnt;
        int         p0;

        reset_L = 1'b0; enable = 1'b0; src_empty = 1'b1;
        src_data = '0; dst_almost_full = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_src_rd", 32'(src_rd), 32'd0);
        check("rst_dst_push", 32'(dst_push), 32'd0);
        check("rst_dst_data", 32'(dst_data), 32'd0);
        check("rst_fwd_count", 32'(fwd_count), 32'd0);
        check("rst_stall_err", 32'(stall_err), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        reset_L = 1'b1;
        tick();

        // Four words, one per destination, no backpressure.
        for (int d = 0; d < 4; d++) load(mk(d));
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            rd_log[i]   = last_rd;
            push_log[i] = last_push;
        end
        f = -1;
        for (int i = 11; i >= 0; i--) if (rd_log[i]) f = i;
        check("t1_first_rd_cycle", 32'(f), 32'd1);
        if (f >= 0 && f <= 6) begin
            for (int j = 0; j < 4; j++) check("t1_rd_run", 32'(rd_log[f+j]), 32'd1);
            check("t1_rd_stop", 32'(rd_log[f+4]), 32'd0);
            check("t1_push_before", 32'(push_log[f+1]), 32'd0);
            for (int j = 0; j < 4; j++) check("t1_push_seq", 32'(push_log[f+2+j]), 32'(4'd1 << j));
        end
        check("t1_fwd_count", 32'(fwd_count), 32'd4);

        // Head for dest 2 blocked; buffer fills and reads stop.
        dst_almost_full = 4'b0100;
        load(mk(2)); load(mk(0)); load(mk(1)); load(mk(3));
        cnt = 0; p0 = n_push;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_rd) cnt++;
        end
        check("t2_reads_until_full", 32'(cnt), 32'd2);
        check("t2_no_push_blocked", 32'(n_push - p0), 32'd0);
        check("t2_upstream_left", 32'(upq.size()), 32'd2);
        dst_almost_full = 4'b0000;
        tick();
        check("t2_release_push0", 32'(last_push), 32'b0100);
        tick();
        check("t2_release_push1", 32'(last_push), 32'b0001);
        repeat (8) tick();
        check("t2_stall_err", 32'(stall_err), 32'd0);
        check("t2_all_out", 32'(exp_q.size() + upq.size()), 32'd0);

        // Dest 1 head blocked long enough to raise stall_err.
        dst_almost_full = 4'b0010;
        load(mk(1));
        cnt = 0;
        while (cnt < 5) begin
            tick();
            cnt++;
            if (last_rd) break;
        end
        check("t3_read_seen", 32'(last_rd), 32'd1);
        tick();
        repeat (14) tick();
        check("t3_stall_before", 32'(stall_err), 32'd0);
        tick();
        check("t3_stall_set", 32'(stall_err), 32'd1);
        dst_almost_full = 4'b0000;
        repeat (3) tick();
        check("t3_stall_sticky", 32'(stall_err), 32'd1);
        check("t3_word_out", 32'(exp_q.size()), 32'd0);

        // Enable drops in the same cycle a read is issued.
        load(mk(3)); load(mk(0)); load(mk(2));
        enable = 1'b0;
        #1;
        check("t4_rd_at_drop", 32'(src_rd), 32'd1);
        p0 = n_push; cnt = 0;
        tick(); tick(); tick();
        check("t4_push_pending", 32'(last_push != 4'd0), 32'd1);
        check("t4_idle_at_push", 32'(idle), 32'd0);
        tick();
        check("t4_idle_after", 32'(idle), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_rd) cnt++;
        end
        check("t4_no_more_rd", 32'(cnt), 32'd0);
        check("t4_one_push", 32'(n_push - p0), 32'd1);

        // Asynchronous reset with both buffer entries held.
        dst_almost_full = 4'hF;
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_rd) cnt++;
        end
        check("t5_buffer_full_reads", 32'(cnt), 32'd2);
        reset_L = 1'b0;
        #1;
        check("t5_async_push", 32'(dst_push), 32'd0);
        check("t5_async_count", 32'(fwd_count), 32'd0);
        check("t5_async_data", 32'(dst_data), 32'd0);
        check("t5_async_idle", 32'(idle), 32'd1);
        exp_q.delete();
        model_cnt = 0; prev_data = '0;
        enable = 1'b0; dst_almost_full = 4'd0;
        tick(); tick();
        reset_L = 1'b1;
        p0 = n_push;
        repeat (6) tick();
        check("t5_no_push_after", 32'(n_push - p0), 32'd0);

        // Counter wrap with a 4-bit counter.
        enable = 1'b1;
        for (int i = 0; i < 17; i++) load(mk(int'($urandom_range(0, 3))));
        for (int i = 0; i < 60; i++) begin
            tick();
            if (upq.size() == 0 && exp_q.size() == 0 && !last_rd) break;
        end
        check("t6_wrap_count", 32'(fwd_count), 32'd1);

        // Randomized traffic, backpressure and enable toggling.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0 && upq.size() < 8) load(mk(int'($urandom_range(0, 3))));
            dst_almost_full = 4'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            tick();
        end
        dst_almost_full = 4'd0;
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (upq.size() == 0 && exp_q.size() == 0 && !last_rd) break;
        end
        check("rand_drained", 32'(exp_q.size() + upq.size()), 32'd0);
        enable = 1'b0;
        repeat (4) tick();
        check("rand_idle", 32'(idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
